// File: rtl/rom_t_reader.sv
// Block fetcher for the combinational T-coefficient ROM banks, presented to the MAC as a valid/ready stream.
// Latency: first word valid WAIT_CYC+1 edges after start; then one word per WAIT_CYC+2 cycles at best.
// Backpressure: a presented word, its index and the ROM address hold until o_data_valid & i_data_ready.
module rom_t_reader #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic              c_clk,
    input  logic              c_rst_n,
    input  logic              c_start,
    input  logic [ADDR_W-1:0] i_first_addr,
    input  logic [ADDR_W:0]   i_count,
    output logic [ADDR_W-1:0] o_rom_address,
    output logic              c_rom_read_en,
    output logic              c_rom_ce,
    output logic              c_rom_tri_output,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [ADDR_W:0]   o_index,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      SETTLE = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t          state;
    logic [3:0]      settle_cnt;
    logic [ADDR_W:0] last_idx;
    logic [ADDR_W:0] count_clamped;

    // Oversized requests read the whole bank once rather than wrapping past it.
    assign count_clamped = (i_count > DEPTH) ? DEPTH : i_count;

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            state            <= ST_IDLE;
            settle_cnt       <= '0;
            last_idx         <= '0;
            o_rom_address    <= '0;
            c_rom_read_en    <= 1'b0;
            c_rom_ce         <= 1'b0;
            c_rom_tri_output <= 1'b1;
            o_data           <= '0;
            o_data_valid     <= 1'b0;
            o_index          <= '0;
            o_last           <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (c_start) begin
                        if (count_clamped != '0) begin
                            o_rom_address    <= i_first_addr;
                            c_rom_ce         <= 1'b1;
                            c_rom_read_en    <= 1'b1;
                            c_rom_tri_output <= 1'b0;
                            o_busy           <= 1'b1;
                            settle_cnt       <= SETTLE;
                            o_index          <= '0;
                            last_idx         <= count_clamped - 1'b1;
                            state            <= ST_WAIT;
                        end else begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        o_data       <= i_rom_data;
                        o_data_valid <= 1'b1;
                        o_last       <= (o_index == last_idx);
                        state        <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_data_ready) begin
                        o_data_valid <= 1'b0;
                        if (o_last) begin
                            c_rom_ce         <= 1'b0;
                            c_rom_read_en    <= 1'b0;
                            c_rom_tri_output <= 1'b1;
                            o_busy           <= 1'b0;
                            o_done           <= 1'b1;
                            state            <= ST_DONE;
                        end else begin
                            o_rom_address <= o_rom_address + 1'b1;
                            o_index       <= o_index + 1'b1;
                            settle_cnt    <= SETTLE;
                            state         <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_t_reader.sv
// Directed bench for rom_t_reader against a bank x6 ROM model; two extra instances compare settle delays.
module tb_rom_t_reader;

    logic        clk;
    logic        rst_n;
    logic        start, start_b;
    logic [2:0]  first_addr;
    logic [3:0]  count;
    logic [2:0]  rom_addr, rom_addr0, rom_addr3;
    logic        rom_rd, rom_ce, rom_tri;
    logic        rom_rd0, rom_ce0, rom_tri0, rom_rd3, rom_ce3, rom_tri3;
    logic [15:0] rom_dat, rom_dat0, rom_dat3;
    logic [15:0] data, data0, data3;
    logic        valid, valid0, valid3;
    logic        ready, ready_b;
    logic [3:0]  index, index0, index3;
    logic        last, last0, last3;
    logic        busy, busy0, busy3;
    logic        done, done0, done3;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_dat[$];
    logic [3:0]  q_idx[$];
    logic [2:0]  q_adr[$];
    logic        q_last[$];
    int          done_cnt;
    bit          ce_seen;

    function automatic logic [15:0] rom_word(input logic [2:0] a);
        case (a)
            3'd0: rom_word = 16'h7FFF;
            3'd1: rom_word = 16'h4FFF;
            3'd2: rom_word = 16'hE400;
            3'd3: rom_word = 16'h8D00;
            3'd4: rom_word = 16'h8C40;
            3'd5: rom_word = 16'hE250;
            3'd6: rom_word = 16'h4EA3;
            default: rom_word = 16'h7FFC;
        endcase
    endfunction

    assign rom_dat  = (rom_ce  && rom_rd  && !rom_tri)  ? rom_word(rom_addr)  : 16'hDEAD;
    assign rom_dat0 = (rom_ce0 && rom_rd0 && !rom_tri0) ? rom_word(rom_addr0) : 16'hDEAD;
    assign rom_dat3 = (rom_ce3 && rom_rd3 && !rom_tri3) ? rom_word(rom_addr3) : 16'hDEAD;

    rom_t_reader #(.ADDR_W(3), .DATA_W(16), .WAIT_CYC(1)) dut (
        .c_clk(clk), .c_rst_n(rst_n), .c_start(start),
        .i_first_addr(first_addr), .i_count(count),
        .o_rom_address(rom_addr), .c_rom_read_en(rom_rd), .c_rom_ce(rom_ce),
        .c_rom_tri_output(rom_tri), .i_rom_data(rom_dat),
        .o_data(data), .o_data_valid(valid), .i_data_ready(ready),
        .o_index(index), .o_last(last), .o_busy(busy), .o_done(done)
    );

    rom_t_reader #(.ADDR_W(3), .DATA_W(16), .WAIT_CYC(0)) dut_w0 (
        .c_clk(clk), .c_rst_n(rst_n), .c_start(start_b),
        .i_first_addr(3'd0), .i_count(4'd2),
        .o_rom_address(rom_addr0), .c_rom_read_en(rom_rd0), .c_rom_ce(rom_ce0),
        .c_rom_tri_output(rom_tri0), .i_rom_data(rom_dat0),
        .o_data(data0), .o_data_valid(valid0), .i_data_ready(ready_b),
        .o_index(index0), .o_last(last0), .o_busy(busy0), .o_done(done0)
    );

    rom_t_reader #(.ADDR_W(3), .DATA_W(16), .WAIT_CYC(3)) dut_w3 (
        .c_clk(clk), .c_rst_n(rst_n), .c_start(start_b),
        .i_first_addr(3'd0), .i_count(4'd2),
        .o_rom_address(rom_addr3), .c_rom_read_en(rom_rd3), .c_rom_ce(rom_ce3),
        .c_rom_tri_output(rom_tri3), .i_rom_data(rom_dat3),
        .o_data(data3), .o_data_valid(valid3), .i_data_ready(ready_b),
        .o_index(index3), .o_last(last3), .o_busy(busy3), .o_done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    // Runs one block with ready tied high, logging every presented word.
    task automatic run_block(input logic [2:0] addr, input logic [3:0] cnt, input int pulse_at);
        int post;
        q_dat.delete(); q_idx.delete(); q_adr.delete(); q_last.delete();
        done_cnt = 0;
        ce_seen  = 1'b0;
        post     = 0;
        ready = 1'b1; first_addr = addr; count = cnt; start = 1'b1;
        tick;
        start = 1'b0; first_addr = addr + 3'd3; count = 4'd1;
        for (int n = 0; n < 200 && post < 3; n++) begin
            if (valid) begin
                q_dat.push_back(data); q_idx.push_back(index);
                q_adr.push_back(rom_addr); q_last.push_back(last);
            end
            if (done) done_cnt++;
            if (rom_ce) ce_seen = 1'b1;
            if (done_cnt > 0) post++;
            start = (n == pulse_at);
            if (n == pulse_at) first_addr = 3'd5;
            tick;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_addr, rom_rd, rom_ce, rom_tri, data, valid, index, last, busy, done} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr=%0d rd=%b ce=%b tri=%b data=%h vld=%b idx=%0d last=%b busy=%b done=%b, required 0 0 0 1 0000 0 0 0 0 0",
                     rom_addr, rom_rd, rom_ce, rom_tri, data, valid, index, last, busy, done);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if ({busy, done, valid0, valid3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b v0=%b v3=%b, required all 0", busy, done, valid0, valid3);
        end
    endtask

    task automatic test_full_bank;
        logic [15:0] exp_w[8] = '{16'h7FFF, 16'h4FFF, 16'hE400, 16'h8D00,
                                  16'h8C40, 16'hE250, 16'h4EA3, 16'h7FFC};
        run_block(3'd0, 4'd8, -1);
        checks++;
        if (q_dat.size() != 8) begin
            errors++; $display("FAIL full_count: got %0d words, required 8", q_dat.size());
        end
        for (int k = 0; k < q_dat.size() && k < 8; k++) begin
            checks++;
            if ({q_dat[k], q_idx[k], q_last[k]} !== {exp_w[k], 4'(k), (k == 7)}) begin
                errors++;
                $display("FAIL full_word%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                         k, q_dat[k], q_idx[k], q_last[k], exp_w[k], k, (k == 7));
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL full_done: got %0d pulses, required 1", done_cnt);
        end
        checks++;
        if ({rom_ce, rom_rd, rom_tri, busy} !== 4'b0010) begin
            errors++; $display("FAIL full_final: ce=%b rd=%b tri=%b busy=%b, required 0 0 1 0", rom_ce, rom_rd, rom_tri, busy);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_w[4] = '{16'h4EA3, 16'h7FFC, 16'h7FFF, 16'h4FFF};
        logic [2:0]  exp_a[4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        run_block(3'd6, 4'd4, -1);
        checks++;
        if (q_dat.size() != 4) begin
            errors++; $display("FAIL wrap_count: got %0d words, required 4", q_dat.size());
        end
        for (int k = 0; k < q_dat.size() && k < 4; k++) begin
            checks++;
            if ({q_dat[k], q_adr[k], q_idx[k]} !== {exp_w[k], exp_a[k], 4'(k)}) begin
                errors++;
                $display("FAIL wrap_word%0d: data=%h addr=%0d idx=%0d, required %h %0d %0d",
                         k, q_dat[k], q_adr[k], q_idx[k], exp_w[k], exp_a[k], k);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        ready = 1'b0; first_addr = 3'd0; count = 4'd3; start = 1'b1;
        tick;
        start = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_first_timeout: valid=0, required 1"); end
        ready = 1'b1; tick; ready = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'h4FFF || index !== 4'd1) begin
            errors++; $display("FAIL bp_second: ok=%b data=%h idx=%0d, required 1 4fff 1", ok, data, index);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({valid, data, index, rom_addr} !== {1'b1, 16'h4FFF, 4'd1, 3'd1}) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b data=%h idx=%0d addr=%0d, required 1 4fff 1 1", i, valid, data, index, rom_addr);
            end
        end
        ready = 1'b1; tick; ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b, required 0", valid); end
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'hE400 || index !== 4'd2 || last !== 1'b1) begin
            errors++; $display("FAIL bp_next: ok=%b data=%h idx=%0d last=%b, required 1 e400 2 1", ok, data, index, last);
        end
        ready = 1'b1; tick; ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done: done=%b, required 1", done); end
        tick;
    endtask

    task automatic test_count_edges;
        first_addr = 3'd2; count = 4'd0; ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({done, busy, rom_ce, rom_rd, rom_tri} !== 5'b10001) begin
            errors++; $display("FAIL zero_pulse: done=%b busy=%b ce=%b rd=%b tri=%b, required 1 0 0 0 1", done, busy, rom_ce, rom_rd, rom_tri);
        end
        tick;
        checks++;
        if ({done, rom_ce} !== 2'b00) begin
            errors++; $display("FAIL zero_end: done=%b ce=%b, required 0 0", done, rom_ce);
        end
        run_block(3'd0, 4'd0, -1);
        checks++;
        if (ce_seen || q_dat.size() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_block: ce_seen=%b words=%0d done=%0d, required 0 0 1", ce_seen, q_dat.size(), done_cnt);
        end
        run_block(3'd0, 4'd15, -1);
        checks++;
        if (q_dat.size() != 8 || q_dat[7] !== 16'h7FFC || q_last[7] !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL clamp_15: words=%0d done=%0d, required 8 words ending 7ffc with last, 1 done", q_dat.size(), done_cnt);
        end
        run_block(3'd2, 4'd3, 3);
        checks++;
        if (q_dat.size() != 3 || q_dat[0] !== 16'hE400 || q_dat[1] !== 16'h8D00 ||
            q_dat[2] !== 16'h8C40 || done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL start_ignored: words=%0d done=%0d busy=%b, required e400 8d00 8c40, 1 done, idle", q_dat.size(), done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        ok = 1'b0;
        ready = 1'b1; first_addr = 3'd0; count = 4'd8; start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (valid && index == 4'd2) begin ok = 1'b1; break; end
            tick;
        end
        tick;
        checks++;
        if (!ok || valid !== 1'b0 || rom_addr !== 3'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_wait3: ok=%b vld=%b addr=%0d busy=%b, required 1 0 3 1", ok, valid, rom_addr, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_addr, rom_rd, rom_ce, rom_tri, data, valid, index, last, busy, done} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: addr=%0d rd=%b ce=%b tri=%b data=%h vld=%b idx=%0d busy=%b done=%b, required 0 0 0 1 0000 0 0 0 0",
                     rom_addr, rom_rd, rom_ce, rom_tri, data, valid, index, busy, done);
        end
        #2 rst_n = 1'b1;
        tick; tick;
        checks++;
        if ({busy, rom_ce, valid} !== 3'b000) begin
            errors++; $display("FAIL mid_no_resume: busy=%b ce=%b vld=%b, required 0 0 0", busy, rom_ce, valid);
        end
        run_block(3'd4, 4'd2, -1);
        checks++;
        if (q_dat.size() != 2 || q_dat[0] !== 16'h8C40 || q_dat[1] !== 16'hE250 || q_adr[0] !== 3'd4) begin
            errors++; $display("FAIL mid_restart: words=%0d, required 8c40 e250 from address 4", q_dat.size());
        end
    endtask

    task automatic test_latency;
        int lat0, lat3;
        logic [15:0] w0[$];
        logic [15:0] w3[$];
        lat0 = 0; lat3 = 0;
        ready_b = 1'b1; start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (valid0 && lat0 == 0) lat0 = n - 1;
            if (valid3 && lat3 == 0) lat3 = n - 1;
            if (valid0) w0.push_back(data0);
            if (valid3) w3.push_back(data3);
            tick;
        end
        checks++;
        if (lat0 != 1) begin errors++; $display("FAIL latency_w0: got %0d edges, required 1", lat0); end
        checks++;
        if (lat3 != 4) begin errors++; $display("FAIL latency_w3: got %0d edges, required 4", lat3); end
        checks++;
        if (w0.size() != 2 || w0[0] !== 16'h7FFF || w0[1] !== 16'h4FFF) begin
            errors++; $display("FAIL data_w0: words=%0d, required 7fff 4fff", w0.size());
        end
        checks++;
        if (w3.size() != 2 || w3[0] !== 16'h7FFF || w3[1] !== 16'h4FFF) begin
            errors++; $display("FAIL data_w3: words=%0d, required 7fff 4fff", w3.size());
        end
    endtask

    initial begin
        start = 1'b0; start_b = 1'b0; ready = 1'b0; ready_b = 1'b0;
        first_addr = 3'd0; count = 4'd0; rst_n = 1'b1;
        test_reset;
        test_full_bank;
        test_wrap;
        test_backpressure;
        test_count_edges;
        test_reset_mid;
        test_latency;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
